uart_byte_tx: RTL and testbench
===============================

// Module: uart_byte_tx
// PURPOSE
//  Serial UART transmitter: accepts one byte per uart_tx_en strobe and shifts it out on uart_txd.
//  Sits directly downstream of time_send, consuming its uart_tx_en/uart_tx_data.
//  Returns a one-cycle uart_tx_done per byte; time_send paces its 20-byte date/time line on it.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  BAUD_RATE  115200      line rate, bit/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (truncated), must be >= 2
//  PARITY     0           0 = none, 1 = odd, 2 = even
//  STOP_BITS  1           1 or 2
// PORTS
//  clk           in   1  system clock
//  rstn          in   1  reset, asynchronous, active-low
//  uart_tx_en    in   1  one-cycle strobe: uart_tx_data is valid, start a frame
//  uart_tx_data  in   8  byte to send, sampled only in the cycle uart_tx_en is high
//  uart_txd      out  1  serial line, idle high, registered
//  uart_tx_busy  out  1  high while a frame is in progress
//  uart_tx_done  out  1  one-cycle pulse at end of each frame's final stop bit
//  uart_tx_drop  out  1  one-cycle pulse when uart_tx_en arrives while busy (byte discarded)
// BEHAVIOUR
//  Reset: uart_txd=1, uart_tx_busy=0, uart_tx_done=0, uart_tx_drop=0, FSM=IDLE, counters 0.
//  Reset mid-frame: the frame is abandoned and uart_txd returns to 1 asynchronously. No done pulse.
//  FSM states: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
//  IDLE: uart_txd=1. If uart_tx_en=1, latch the byte into shift reg and compute parity.
//        Go to START. uart_txd=0 and busy=1 from the next cycle (latency 1 clk).
//  Each bit is held exactly BAUD_DIV clocks, counted by baud_cnt 0..BAUD_DIV-1.
//  On baud_cnt==BAUD_DIV-1, advance; baud_cnt wraps to 0.
//  DATA: 8 bits, LSB first. bit_cnt 0..7; leave DATA when bit_cnt==7 and the bit period ends.
//  PARITY: odd = ~^data; even = ^data; one bit period.
//  STOP: uart_txd=1 for STOP_BITS bit periods.
//  At the end of the last STOP period: FSM=IDLE, busy=0, uart_tx_done=1 for that single cycle.
//  Frame length = BAUD_DIV*(10 + (PARITY!=0) + (STOP_BITS-1)) clocks from first start-bit cycle
//  to the done cycle.
//  uart_tx_en in the same cycle as uart_tx_done is accepted, since FSM is IDLE.
//  Back-to-back frames then have no idle gap.
//  uart_tx_en while busy (not IDLE): ignored. The in-flight frame is unaffected and uart_tx_drop
//  pulses next cycle. time_send's 2-cycle done->en gap never triggers this.
//  uart_tx_data changing while busy has no effect (shift reg is private).
//  uart_txd is driven from a flop; no combinational path from inputs to uart_txd.
//  Widths: baud_cnt = $clog2(BAUD_DIV) bits, bit_cnt 3 bits, stop_cnt 1 bit.
// TESTING
//  1. Defaults, uart_tx_en with 8'h32 -> uart_txd 0,0,1,0,0,1,1,0,0,1 (start,LSB..MSB,stop).
//     Each level held 434 clks; done pulses once, 4340 clks after the start bit's first cycle.
//  2. PARITY=2, byte 8'h32 -> parity bit 1, frame 4774 clks. PARITY=1 -> parity bit 0.
//     STOP_BITS=2 -> stop high for 868 clks.
//  3. Second uart_tx_en at 1000 clks into a frame -> uart_tx_drop pulses once.
//     Frame bits unchanged; only one done pulse.
//  4. rstn low at bit 4 of a frame -> uart_txd=1 and busy=0 immediately, no done.
//     A new uart_tx_en after release sends a clean frame.
//  5. uart_tx_en asserted in the done cycle -> next start bit begins the following cycle.
//     Stop bit is exactly BAUD_DIV clks long.
//  6. Integration with time_send, date_time=48'h220527120000 -> a UART receiver model decodes
//     "2022-05-27 12:00:00\n" (20 bytes); 20 done pulses; busy low afterwards.

Source files
------------

// File: rtl/uart_byte_tx.sv
// Serial UART transmitter: one byte per uart_tx_en strobe, LSB first, optional parity, 1 or 2 stop bits.
// The last stop-bit cycle doubles as the done cycle so a byte strobed there follows with no idle gap.
module uart_byte_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_txd,
    output logic       uart_tx_busy,
    output logic       uart_tx_done,
    output logic       uart_tx_drop
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_PEN  = BW'(BAUD_DIV - 2);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    state_t        state, state_next;
    logic [BW-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic          stop_cnt, stop_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          par_bit, par_bit_next;
    logic          txd_next, busy_next, done_next, drop_next;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            shift        <= '0;
            par_bit      <= 1'b0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
            uart_tx_done <= 1'b0;
            uart_tx_drop <= 1'b0;
        end else begin
            state        <= state_next;
            baud_cnt     <= baud_cnt_next;
            bit_cnt      <= bit_cnt_next;
            stop_cnt     <= stop_cnt_next;
            shift        <= shift_next;
            par_bit      <= par_bit_next;
            uart_txd     <= txd_next;
            uart_tx_busy <= busy_next;
            uart_tx_done <= done_next;
            uart_tx_drop <= drop_next;
        end
    end

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        shift_next    = shift;
        par_bit_next  = par_bit;
        done_next     = 1'b0;
        drop_next     = 1'b0;
        txd_next      = 1'b1;

        unique case (state)
            IDLE: begin
                if (uart_tx_en) begin
                    shift_next    = uart_tx_data;
                    par_bit_next  = (PARITY == 1) ? ~^uart_tx_data : ^uart_tx_data;
                    baud_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    if (bit_cnt == 3'd7) begin
                        stop_cnt_next = 1'b0;
                        state_next    = (PARITY != 0) ? PARITY_BIT : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            PARITY_BIT: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    stop_cnt_next = 1'b0;
                    state_next    = STOP;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                // Leave one cycle early: the first IDLE cycle is the final stop-bit cycle.
                if (stop_cnt == STOP_LAST && baud_cnt == BAUD_PEN) begin
                    baud_cnt_next = '0;
                    stop_cnt_next = 1'b0;
                    done_next     = 1'b1;
                    state_next    = IDLE;
                end else if (baud_end) begin
                    baud_cnt_next = '0;
                    stop_cnt_next = 1'b1;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state != IDLE && uart_tx_en) begin
            drop_next = 1'b1;
        end

        // The line level is registered from the state being entered.
        case (state_next)
            START:      txd_next = 1'b0;
            DATA:       txd_next = shift_next[0];
            PARITY_BIT: txd_next = par_bit_next;
            default:    txd_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: three lanes with different parity/stop/baud settings,
// random bytes scored against a bit-level frame model by a decoupled line monitor.
module tb_uart_byte_tx;

    localparam int N_FRAMES = 10;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   lane_finished [3];

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int lane_id,
                                input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s lane=%0d actual=%0h required=%0h", name, lane_id, actual, expected);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : lane
            localparam int CF    = (g == 2) ? 50_000_000 : (g == 1) ? 700_000 : 1_000_000;
            localparam int BR    = (g == 2) ? 115200 : 100_000;
            localparam int PAR   = (g == 0) ? 1 : (g == 1) ? 2 : 0;
            localparam int SB    = (g == 0) ? 2 : 1;
            localparam int BD    = CF / BR;
            localparam int NB    = 10 + ((PAR != 0) ? 1 : 0) + (SB - 1);
            localparam int TOTAL = NB * BD;

            logic       rstn, en, txd, busy, done, drop;
            logic [7:0] data;
            logic [7:0] exp_q[$];
            bit         mon_en = 1'b0;
            int         done_count = 0;
            int         drop_count = 0;
            int         exp_drops = 0;

            uart_byte_tx #(
                .CLK_FREQ (CF),
                .BAUD_RATE(BR),
                .PARITY   (PAR),
                .STOP_BITS(SB)
            ) dut (
                .clk         (clk),
                .rstn        (rstn),
                .uart_tx_en  (en),
                .uart_tx_data(data),
                .uart_txd    (txd),
                .uart_tx_busy(busy),
                .uart_tx_done(done),
                .uart_tx_drop(drop)
            );

            // Reference line level for bit slot idx of a frame carrying byte d.
            function automatic logic frame_level(input logic [7:0] d, input int idx);
                int ones;
                ones = $countones(d);
                if (idx == 0) return 1'b0;
                if (idx <= 8) return d[idx-1];
                if (idx == 9 && PAR != 0) return (PAR == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
                return 1'b1;
            endfunction

            task automatic apply_stimulus(input logic [7:0] d);
                en   = 1'b1;
                data = d;
                @(negedge clk);
                en   = 1'b0;
                data = 8'($urandom);
            endtask

            task automatic wait_idle();
                int n = 0;
                while (busy !== 1'b0 && n < TOTAL + 20) begin
                    @(negedge clk);
                    n++;
                end
                check_output("idle_timeout", g, 32'(busy !== 1'b0), 0);
            endtask

            task automatic wait_done();
                int n = 0;
                while (done !== 1'b1 && n < TOTAL + 20) begin
                    @(negedge clk);
                    n++;
                end
                check_output("done_timeout", g, 32'(done !== 1'b1), 0);
            endtask

            initial begin : counters
                forever begin
                    @(negedge clk);
                    if (done === 1'b1) done_count++;
                    if (drop === 1'b1) drop_count++;
                end
            end

            initial begin : monitor
                int pend;
                pend = 0;
                forever begin
                    @(negedge clk);
                    if (!mon_en) begin
                        pend = 0;
                        continue;
                    end
                    if (txd === 1'b0) begin
                        logic [7:0] exp_byte, rx_byte;
                        int line_err, busy_err, done_err;
                        if (exp_q.size() == 0) begin
                            check_output("unexpected_start", g, 1, 0);
                            continue;
                        end
                        exp_byte = exp_q.pop_front();
                        rx_byte  = '0;
                        line_err = 0;
                        busy_err = 0;
                        done_err = 0;
                        pend     = 0;
                        for (int k = 0; k < TOTAL; k++) begin
                            if (k > 0) @(negedge clk);
                            if (txd !== frame_level(exp_byte, k / BD)) line_err++;
                            if (busy !== (k < TOTAL - 1)) busy_err++;
                            if (done !== (k == TOTAL - 1)) done_err++;
                            if ((k % BD) == BD / 2 && k / BD >= 1 && k / BD <= 8) rx_byte[k/BD-1] = txd;
                        end
                        check_output("line_bad_cycles", g, line_err, 0);
                        check_output("busy_bad_cycles", g, busy_err, 0);
                        check_output("done_bad_cycles", g, done_err, 0);
                        check_output("decoded_byte", g, rx_byte, exp_byte);
                    end else if (exp_q.size() > 0) begin
                        pend++;
                        if (pend > 2) begin
                            check_output("start_timeout", g, 1, 0);
                            void'(exp_q.pop_front());
                            pend = 0;
                        end
                    end
                end
            end

            initial begin : driver
                logic [7:0] d;
                int r;
                rstn = 1'b0;
                en   = 1'b0;
                data = '0;
                @(negedge clk);
                check_output("reset_txd", g, txd, 1);
                check_output("reset_busy", g, busy, 0);
                check_output("reset_done", g, done, 0);
                check_output("reset_drop", g, drop, 0);
                @(negedge clk);
                rstn = 1'b1;
                @(negedge clk);

                // Abandon a frame mid data bits with an asynchronous reset.
                apply_stimulus(8'($urandom));
                repeat (4 * BD + BD / 2) @(negedge clk);
                check_output("busy_mid_frame", g, busy, 1);
                rstn = 1'b0;
                #1;
                check_output("abort_txd", g, txd, 1);
                check_output("abort_busy", g, busy, 0);
                repeat (2) @(negedge clk);
                rstn = 1'b1;
                repeat (2) @(negedge clk);
                check_output("abort_no_done", g, done_count, 0);
                check_output("abort_idle_txd", g, txd, 1);
                mon_en = 1'b1;
                @(negedge clk);

                for (int i = 0; i < N_FRAMES; i++) begin
                    d = (i == 0) ? 8'h32 : (i == 1) ? 8'h00 : (i == 2) ? 8'hFF : 8'($urandom);
                    if (i % 2 == 1) begin
                        wait_done();
                    end else begin
                        wait_idle();
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                    end
                    exp_q.push_back(d);
                    apply_stimulus(d);
                    if (i == 3 || $urandom_range(0, 3) == 0) begin
                        r = $urandom_range(1, TOTAL - 2);
                        repeat (r) @(negedge clk);
                        apply_stimulus(8'($urandom));
                        exp_drops++;
                    end
                end

                wait_idle();
                repeat (3) @(negedge clk);
                check_output("final_txd", g, txd, 1);
                check_output("final_busy", g, busy, 0);
                check_output("done_count", g, done_count, N_FRAMES);
                check_output("drop_count", g, drop_count, exp_drops);
                check_output("queue_left", g, exp_q.size(), 0);
                lane_finished[g] = 1'b1;
            end
        end
    endgenerate

    initial begin : main
        int cyc;
        cyc = 0;
        while (!(lane_finished[0] && lane_finished[1] && lane_finished[2]) && cyc < 95000) begin
            @(posedge clk);
            cyc++;
        end
        check_output("global_timeout", -1,
                     32'(lane_finished[0] && lane_finished[1] && lane_finished[2]), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
